// File: rtl/rv32i_imm_gen.sv
// RV32I decode-stage immediate generator: all six immediate formats extracted
// in parallel plus an opcode-selected immediate, registered with one cycle latency.
module rv32i_imm_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic            in_valid,
  output logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] i_shift_imm,
  output logic [XLEN-1:0] s_imm,
  output logic [XLEN-1:0] u_imm,
  output logic [XLEN-1:0] j_imm,
  output logic [XLEN-1:0] b_imm,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            out_valid
);

  typedef enum logic [2:0] {
    IMM_NONE   = 3'd0,
    IMM_I      = 3'd1,
    IMM_ISHIFT = 3'd2,
    IMM_S      = 3'd3,
    IMM_U      = 3'd4,
    IMM_J      = 3'd5,
    IMM_B      = 3'd6
  } imm_type_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  logic            sign;
  logic [2:0]      funct3;
  opcode_e         opcode;

  logic [XLEN-1:0] i_imm_c;
  logic [XLEN-1:0] i_shift_imm_c;
  logic [XLEN-1:0] s_imm_c;
  logic [XLEN-1:0] u_imm_c;
  logic [XLEN-1:0] j_imm_c;
  logic [XLEN-1:0] b_imm_c;
  logic [XLEN-1:0] sel_imm;
  imm_type_e       sel_type;

  assign sign   = instruction[31];
  assign funct3 = instruction[14:12];
  assign opcode = opcode_e'(instruction[6:0]);

  // Format extraction ignores opcode/funct; sign always comes from bit 31.
  assign i_imm_c       = {{(XLEN-12){sign}}, instruction[31:20]};
  assign i_shift_imm_c = {{(XLEN-5){1'b0}}, instruction[24:20]};
  assign s_imm_c       = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
  assign u_imm_c       = {instruction[31:12], 12'b0};
  assign j_imm_c       = {{(XLEN-21){sign}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
  assign b_imm_c       = {{(XLEN-13){sign}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};

  always_comb begin
    sel_type = IMM_NONE;
    sel_imm  = '0;
    case (opcode)
      OP_IMM: begin
        // slli/srli/srai use the shamt field rather than the 12-bit immediate
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          sel_type = IMM_ISHIFT;
          sel_imm  = i_shift_imm_c;
        end else begin
          sel_type = IMM_I;
          sel_imm  = i_imm_c;
        end
      end
      OP_LOAD, OP_JALR: begin
        sel_type = IMM_I;
        sel_imm  = i_imm_c;
      end
      OP_STORE: begin
        sel_type = IMM_S;
        sel_imm  = s_imm_c;
      end
      OP_LUI, OP_AUIPC: begin
        sel_type = IMM_U;
        sel_imm  = u_imm_c;
      end
      OP_JAL: begin
        sel_type = IMM_J;
        sel_imm  = j_imm_c;
      end
      OP_BRANCH: begin
        sel_type = IMM_B;
        sel_imm  = b_imm_c;
      end
      default: begin
        sel_type = IMM_NONE;
        sel_imm  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_imm       <= '0;
      i_shift_imm <= '0;
      s_imm       <= '0;
      u_imm       <= '0;
      j_imm       <= '0;
      b_imm       <= '0;
      imm         <= '0;
      imm_type    <= '0;
      out_valid   <= 1'b0;
    end else begin
      i_imm       <= i_imm_c;
      i_shift_imm <= i_shift_imm_c;
      s_imm       <= s_imm_c;
      u_imm       <= u_imm_c;
      j_imm       <= j_imm_c;
      b_imm       <= b_imm_c;
      imm         <= sel_imm;
      imm_type    <= sel_type;
      out_valid   <= in_valid;
    end
  end

endmodule

// File: tb/tb_rv32i_imm_gen.sv
// Directed, table-driven bench for rv32i_imm_gen with hand-computed expectations
// and hand-written reset/latency sequences.
module tb_rv32i_imm_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        in_valid;
  logic [31:0] i_imm, i_shift_imm, s_imm, u_imm, j_imm, b_imm, imm;
  logic [2:0]  imm_type;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_imm_gen #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .in_valid    (in_valid),
    .i_imm       (i_imm),
    .i_shift_imm (i_shift_imm),
    .s_imm       (s_imm),
    .u_imm       (u_imm),
    .j_imm       (j_imm),
    .b_imm       (b_imm),
    .imm         (imm),
    .imm_type    (imm_type),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        vld;
    logic [31:0] e_i;
    logic [31:0] e_sh;
    logic [31:0] e_s;
    logic [31:0] e_u;
    logic [31:0] e_j;
    logic [31:0] e_b;
    logic [31:0] e_imm;
    logic [2:0]  e_ty;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " i_imm"},       i_imm,               v.e_i);
    check({tag, " i_shift_imm"}, i_shift_imm,         v.e_sh);
    check({tag, " s_imm"},       s_imm,               v.e_s);
    check({tag, " u_imm"},       u_imm,               v.e_u);
    check({tag, " j_imm"},       j_imm,               v.e_j);
    check({tag, " b_imm"},       b_imm,               v.e_b);
    check({tag, " imm"},         imm,                 v.e_imm);
    check({tag, " imm_type"},    {29'b0, imm_type},   {29'b0, v.e_ty});
    check({tag, " out_valid"},   {31'b0, out_valid},  {31'b0, v.vld});
  endtask

  task automatic check_zero(input string tag);
    vec_t z;
    z = '{32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0};
    check_outputs(tag, z);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    instruction = v.inst;
    in_valid    = v.vld;
  endtask

  initial begin
    //              inst          vld   i_imm         shamt         s_imm         u_imm         j_imm         b_imm         imm           type
    vecs[0]  = '{32'hFFD00000, 1'b1, 32'hFFFFFFFD, 32'h0000001D, 32'hFFFFFFE0, 32'hFFD00000, 32'hFFF00FFC, 32'hFFFFF7E0, 32'h00000000, 3'd0};
    vecs[1]  = '{32'h00A01013, 1'b1, 32'h0000000A, 32'h0000000A, 32'h00000000, 32'h00A01000, 32'h0000100A, 32'h00000000, 32'h0000000A, 3'd2};
    vecs[2]  = '{32'hFE002EA3, 1'b1, 32'hFFFFFFE0, 32'h00000000, 32'hFFFFFFFD, 32'hFE002000, 32'hFFF027E0, 32'hFFFFFFFC, 32'hFFFFFFFD, 3'd3};
    vecs[3]  = '{32'hFFF9C037, 1'b0, 32'hFFFFFFFF, 32'h0000001F, 32'hFFFFFFE0, 32'hFFF9C000, 32'hFFF9CFFE, 32'hFFFFF7E0, 32'hFFF9C000, 3'd4};
    vecs[4]  = '{32'hF39FF06F, 1'b1, 32'hFFFFFF39, 32'h00000019, 32'hFFFFFF20, 32'hF39FF000, 32'hFFFFFF38, 32'hFFFFF720, 32'hFFFFFF38, 3'd5};
    vecs[5]  = '{32'hFC000CE3, 1'b1, 32'hFFFFFFC0, 32'h00000000, 32'hFFFFFFD9, 32'hFC000000, 32'hFFF007C0, 32'hFFFFFFD8, 32'hFFFFFFD8, 3'd6};
    vecs[6]  = '{32'h80002083, 1'b1, 32'hFFFFF800, 32'h00000000, 32'hFFFFF801, 32'h80002000, 32'hFFF02000, 32'hFFFFF800, 32'hFFFFF800, 3'd1};
    vecs[7]  = '{32'h7FF00013, 1'b0, 32'h000007FF, 32'h0000001F, 32'h000007E0, 32'h7FF00000, 32'h00000FFE, 32'h000007E0, 32'h000007FF, 3'd1};
    vecs[8]  = '{32'h40F05013, 1'b1, 32'h0000040F, 32'h0000000F, 32'h00000400, 32'h40F05000, 32'h00005C0E, 32'h00000400, 32'h0000000F, 3'd2};
    vecs[9]  = '{32'h12345017, 1'b1, 32'h00000123, 32'h00000003, 32'h00000120, 32'h12345000, 32'h00045922, 32'h00000120, 32'h12345000, 3'd4};
    vecs[10] = '{32'h00008067, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h00008000, 32'h00000000, 32'h00000000, 3'd1};
    vecs[11] = '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h0000001F, 32'hFFFFFFFF, 32'hFFFFF000, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000000, 3'd0};
    vecs[12] = '{32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 3'd0};

    // Reset with a busy, valid input: everything must still clear.
    rst         = 1'b1;
    instruction = 32'hFFFFFFFF;
    in_valid    = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");

    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream: a new instruction every cycle, checked one edge later.
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k]);
      @(posedge clk);
      #1 check_outputs($sformatf("vec%0d", k), vecs[k]);
    end

    // Latency: a freshly driven instruction must not show before the next edge.
    drive(vecs[1]);
    @(posedge clk);
    #1 check_outputs("lat_load", vecs[1]);
    @(negedge clk);
    instruction = vecs[5].inst;
    in_valid    = vecs[5].vld;
    #1 check_outputs("lat_hold", vecs[1]);
    @(posedge clk);
    #1 check_outputs("lat_b", vecs[5]);

    // Mid-stream reset for one cycle flushes, then results resume one edge later.
    @(negedge clk);
    rst         = 1'b1;
    instruction = vecs[4].inst;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    instruction = vecs[2].inst;
    in_valid    = vecs[2].vld;
    #1 check_zero("midrst_hold");
    @(posedge clk);
    #1 check_outputs("post_rst", vecs[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
